// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for two producers sharing one FIFO,
// with a per-ownership burst limit and empty-gated consumer reads.
module fifo_wr_arbiter #(
   parameter int unsigned BURST = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt1,
   input  logic             fifo_full,
   input  logic             fifo_empty,
   output logic             fifo_write,
   output logic [WIDTH-1:0] fifo_wdata,
   input  logic             rd_req,
   output logic             fifo_read,
   output logic             rd_ack,
   output logic [1:0]       owner,
   output logic [15:0]      wr_total
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] burst_cnt_next;
   logic             rr_next;
   logic             rr_next_d;

   // Read side: consumer pop is only forwarded when the FIFO has data.
   assign fifo_read = rd_req & ~fifo_empty & rst;
   assign rd_ack    = fifo_read;
   assign owner     = state;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state, burst counter and round-robin pointer update.
   always_comb begin
      state_next     = state;
      burst_cnt_next = burst_cnt;
      rr_next_d      = rr_next;
      case (state)
         IDLE: begin
            burst_cnt_next = '0;
            if (req0 && req1) state_next = rr_next ? OWN1 : OWN0;
            else if (req0)    state_next = OWN0;
            else if (req1)    state_next = OWN1;
         end
         OWN0: begin
            if (!req0) begin
               state_next     = req1 ? OWN1 : IDLE;
               rr_next_d      = 1'b1;
               burst_cnt_next = '0;
            end else if (gnt0 && burst_cnt == LAST) begin
               burst_cnt_next = '0;
               if (req1) begin
                  state_next = OWN1;
                  rr_next_d  = 1'b0;
               end
            end else if (gnt0) begin
               burst_cnt_next = burst_cnt + CNT_W'(1);
            end
         end
         OWN1: begin
            if (!req1) begin
               state_next     = req0 ? OWN0 : IDLE;
               rr_next_d      = 1'b0;
               burst_cnt_next = '0;
            end else if (gnt1 && burst_cnt == LAST) begin
               burst_cnt_next = '0;
               if (req0) begin
                  state_next = OWN0;
                  rr_next_d  = 1'b1;
               end
            end else if (gnt1) begin
               burst_cnt_next = burst_cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Write-side outputs: the owner is granted whenever the FIFO has room.
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      fifo_wdata = '0;
      case (state)
         OWN0: begin
            gnt0 = rst & req0 & ~fifo_full;
            if (gnt0) fifo_wdata = data0;
         end
         OWN1: begin
            gnt1 = rst & req1 & ~fifo_full;
            if (gnt1) fifo_wdata = data1;
         end
         default: ;
      endcase
      fifo_write = gnt0 | gnt1;
   end

   // Burst counter and round-robin preference.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_cnt <= '0;
         rr_next   <= 1'b0;
      end else begin
         burst_cnt <= burst_cnt_next;
         rr_next   <= rr_next_d;
      end
   end

   // Running count of accepted writes, wrapping naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            wr_total <= '0;
      else if (fifo_write) wr_total <= wr_total + 16'd1;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus
// hand-written sequences for bursts, full stalls and async reset.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [7:0]  data0, data1;
   logic        gnt0, gnt1;
   logic        fifo_full, fifo_empty;
   logic        fifo_write;
   logic [7:0]  fifo_wdata;
   logic        rd_req, fifo_read, rd_ack;
   logic [1:0]  owner;
   logic [15:0] wr_total;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.BURST(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .data1(data1), .gnt1(gnt1),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_write(fifo_write), .fifo_wdata(fifo_wdata),
      .rd_req(rd_req), .fifo_read(fifo_read), .rd_ack(rd_ack),
      .owner(owner), .wr_total(wr_total)
   );

   typedef struct {
      logic       r, q0, q1;
      logic [7:0] d0, d1;
      logic       f, e, rd;
      logic       g0, g1, w;
      logic [7:0] wd;
      logic       rs;
      logic [1:0] own;
      logic [15:0] tot;
   } vec_t;

   localparam int NV = 19;
   vec_t vt [NV];

   function automatic vec_t mk(input logic r, q0, q1, input logic [7:0] d0, d1,
                               input logic f, e, rd, g0, g1, w,
                               input logic [7:0] wd, input logic rs,
                               input logic [1:0] own, input logic [15:0] tot);
      vec_t v;
      v.r = r; v.q0 = q0; v.q1 = q1; v.d0 = d0; v.d1 = d1;
      v.f = f; v.e = e; v.rd = rd; v.g0 = g0; v.g1 = g1; v.w = w;
      v.wd = wd; v.rs = rs; v.own = own; v.tot = tot;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
      fifo_full = 1'b0; fifo_empty = 1'b1; rd_req = 1'b0;
      next_cycle();
      rst = 1'b1;
   endtask

   initial begin
      //         r  q0 q1 d0     d1     f  e  rd   g0 g1 w  wd     rs own tot
      vt[0]  = mk(0, 1, 1, 8'hA5, 8'h5A, 0, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
      vt[1]  = mk(1, 0, 0, 8'hA5, 8'h5A, 0, 1, 1,  0, 0, 0, 8'h00, 0, 0, 0);
      vt[2]  = mk(1, 0, 0, 8'hA5, 8'h5A, 0, 0, 1,  0, 0, 0, 8'h00, 1, 0, 0);
      vt[3]  = mk(1, 1, 0, 8'hA5, 8'h5A, 0, 1, 0,  0, 0, 0, 8'h00, 0, 0, 0);
      vt[4]  = mk(1, 1, 0, 8'hA5, 8'h5A, 0, 1, 0,  1, 0, 1, 8'hA5, 0, 1, 0);
      vt[5]  = mk(1, 0, 0, 8'hA5, 8'h5A, 0, 1, 0,  0, 0, 0, 8'h00, 0, 1, 1);
      vt[6]  = mk(0, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  0, 0, 0, 8'h00, 0, 0, 0);
      vt[7]  = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  0, 0, 0, 8'h00, 0, 0, 0);
      vt[8]  = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  1, 0, 1, 8'h30, 0, 1, 0);
      vt[9]  = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  1, 0, 1, 8'h30, 0, 1, 1);
      vt[10] = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  1, 0, 1, 8'h30, 0, 1, 2);
      vt[11] = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  1, 0, 1, 8'h30, 0, 1, 3);
      vt[12] = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  0, 1, 1, 8'hC3, 0, 2, 4);
      vt[13] = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  0, 1, 1, 8'hC3, 0, 2, 5);
      vt[14] = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  0, 1, 1, 8'hC3, 0, 2, 6);
      vt[15] = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  0, 1, 1, 8'hC3, 0, 2, 7);
      vt[16] = mk(1, 1, 1, 8'h30, 8'hC3, 0, 1, 0,  1, 0, 1, 8'h30, 0, 1, 8);
      vt[17] = mk(1, 0, 1, 8'h30, 8'hC3, 0, 1, 0,  0, 0, 0, 8'h00, 0, 1, 9);
      vt[18] = mk(1, 0, 1, 8'h30, 8'hC3, 0, 1, 0,  0, 1, 1, 8'hC3, 0, 2, 9);

      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
      fifo_full = 1'b0; fifo_empty = 1'b1; rd_req = 1'b0;
      #1;

      // Per-cycle vector table: inputs applied after the edge, outputs sampled mid-cycle.
      for (int i = 0; i < NV; i++) begin
         rst = vt[i].r; req0 = vt[i].q0; req1 = vt[i].q1;
         data0 = vt[i].d0; data1 = vt[i].d1;
         fifo_full = vt[i].f; fifo_empty = vt[i].e; rd_req = vt[i].rd;
         @(negedge clk);
         chk($sformatf("row%0d gnt0", i), 32'(gnt0), 32'(vt[i].g0));
         chk($sformatf("row%0d gnt1", i), 32'(gnt1), 32'(vt[i].g1));
         chk($sformatf("row%0d fifo_write", i), 32'(fifo_write), 32'(vt[i].w));
         chk($sformatf("row%0d fifo_wdata", i), 32'(fifo_wdata), 32'(vt[i].wd));
         chk($sformatf("row%0d fifo_read", i), 32'(fifo_read), 32'(vt[i].rs));
         chk($sformatf("row%0d rd_ack", i), 32'(rd_ack), 32'(vt[i].rs));
         chk($sformatf("row%0d owner", i), 32'(owner), 32'(vt[i].own));
         chk($sformatf("row%0d wr_total", i), 32'(wr_total), 32'(vt[i].tot));
         next_cycle();
      end

      // Single producer, 10 back-to-back writes without rotation.
      do_reset();
      req0 = 1'b1; data0 = 8'h66;
      @(negedge clk);
      chk("single idle write", 32'(fifo_write), 32'd0);
      next_cycle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("single gnt0 #%0d", i), 32'(gnt0), 32'd1);
         chk($sformatf("single owner #%0d", i), 32'(owner), 32'd1);
         chk($sformatf("single wdata #%0d", i), 32'(fifo_wdata), 32'h66);
         next_cycle();
      end
      req0 = 1'b0;
      @(negedge clk);
      chk("single wr_total", 32'(wr_total), 32'd10);
      chk("single no write", 32'(fifo_write), 32'd0);
      next_cycle();

      // Full stall in OWN1 with a concurrent read; burst count must freeze.
      do_reset();
      req1 = 1'b1; data1 = 8'h77;
      @(negedge clk);
      chk("stall idle owner", 32'(owner), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("stall first gnt1", 32'(gnt1), 32'd1);
      next_cycle();
      fifo_full = 1'b1; req0 = 1'b1; data0 = 8'h44; rd_req = 1'b1; fifo_empty = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall gnt1 #%0d", i), 32'(gnt1), 32'd0);
         chk($sformatf("stall write #%0d", i), 32'(fifo_write), 32'd0);
         chk($sformatf("stall owner #%0d", i), 32'(owner), 32'd2);
         chk($sformatf("stall read #%0d", i), 32'(fifo_read), 32'd1);
         next_cycle();
      end
      fifo_full = 1'b0; rd_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("resume gnt1 #%0d", i), 32'(gnt1), 32'd1);
         chk($sformatf("resume wdata #%0d", i), 32'(fifo_wdata), 32'h77);
         next_cycle();
      end
      @(negedge clk);
      chk("handover gnt0", 32'(gnt0), 32'd1);
      chk("handover owner", 32'(owner), 32'd1);
      next_cycle();
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk("stall wr_total", 32'(wr_total), 32'd5);
      next_cycle();

      // Asynchronous reset in the middle of a P0 burst.
      do_reset();
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
      @(negedge clk);
      chk("areset idle owner", 32'(owner), 32'd0);
      next_cycle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("areset pre gnt0 #%0d", i), 32'(gnt0), 32'd1);
         next_cycle();
      end
      @(negedge clk);
      chk("areset pre write", 32'(fifo_write), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("areset write drop", 32'(fifo_write), 32'd0);
      chk("areset owner", 32'(owner), 32'd0);
      chk("areset wr_total", 32'(wr_total), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("post gnt0 #%0d", i), 32'(gnt0), 32'd1);
         chk($sformatf("post owner #%0d", i), 32'(owner), 32'd1);
         next_cycle();
      end
      @(negedge clk);
      chk("post handover gnt1", 32'(gnt1), 32'd1);
      chk("post handover owner", 32'(owner), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
